// File: rtl/instr_fetch_pkg.sv
// Shared defaults for the instruction fetch unit and its buffer.
// NOP_INSTR is the word decode should treat as a bubble when nothing is valid.
package instr_fetch_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 4;

  localparam logic [DEF_DATA_W-1:0] NOP_INSTR = '0;
endpackage

// File: rtl/instr_fetch_if.sv
// PC request, instruction memory and decode-side bus of the fetch unit.
// master = fetch unit side, slave = environment (PC, memory, decode).
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              pc_ready;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              ir_valid;
  logic              ir_ready;
  logic [DATA_W-1:0] ir_data;
  logic [ADDR_W-1:0] ir_pc;

  modport master (
    input  pc_in, pc_valid, imem_rdata, ir_ready,
    output pc_ready, imem_req, imem_addr, ir_valid, ir_data, ir_pc
  );

  modport slave (
    output pc_in, pc_valid, imem_rdata, ir_ready,
    input  pc_ready, imem_req, imem_addr, ir_valid, ir_data, ir_pc
  );
endinterface

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: synchronous FIFO, registered push/pop, head read combinationally from the array.
// Latency 1 cycle push-to-head; caller must never push when full or pop when empty.
module fetch_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [WIDTH-1:0]         head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data array is not reset; consumers qualify head with occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_dat;
  end

  assign occupancy = count;
  assign head      = mem[rptr];
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC -> imem read -> buffered {pc, instr}; 2-cycle PC-to-ir_valid latency.
// Credits count buffered plus in-flight reads, so pc_ready drops before the buffer can overflow.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  instr_fetch_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [CNT_W-1:0]  occ;
  logic [CNT_W:0]    credit_used;
  logic              inflight;
  logic [ADDR_W-1:0] tag_pc;
  logic [ENT_W-1:0]  head;
  logic              accept;
  logic              push;
  logic              pop;

  assign credit_used  = {1'b0, occ} + {{CNT_W{1'b0}}, inflight};
  assign bus.pc_ready = reset && !flush && (credit_used < (CNT_W+1)'(DEPTH));
  assign accept       = bus.pc_valid && bus.pc_ready;
  assign bus.imem_req  = accept;
  assign bus.imem_addr = bus.pc_in;

  // accept is already low under flush or reset, so inflight clears on its own.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight <= 1'b0;
      tag_pc   <= '0;
    end else begin
      inflight <= accept;
      tag_pc   <= bus.pc_in;
    end
  end

  // Data returning during a flush belongs to a discarded fetch.
  assign push = inflight && !flush && reset;
  assign pop  = bus.ir_valid && bus.ir_ready;

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push),
    .push_dat  ({tag_pc, bus.imem_rdata}),
    .pop       (pop),
    .occupancy (occ),
    .head      (head)
  );

  assign bus.ir_valid = reset && !flush && (occ != '0);
  assign bus.ir_pc    = head[ENT_W-1 -: ADDR_W];
  assign bus.ir_data  = bus.ir_valid ? head[DATA_W-1:0] : DATA_W'(NOP_INSTR);
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal checks plus random traffic,
// all cycles checked against a queue-based model of outstanding fetches.
module tb_instr_fetch;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  // Instruction memory: word = addr ^ 0xA500, one cycle after the strobe; junk otherwise.
  logic          had_req = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] junk = '0;
  always @(posedge clk) begin
    had_req   <= bus.imem_req;
    last_addr <= bus.imem_addr;
    junk      <= DW'($urandom);
  end
  assign bus.imem_rdata = had_req ? (16'hA500 ^ {8'h00, last_addr}) : junk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_pop  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: every accepted fetch is an outstanding entry that becomes visible
  // two cycles after acceptance; credit = number of outstanding entries.
  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
    int            avail;
  } ent_t;
  ent_t q[$];
  int   cyc = 0;

  always @(negedge clk) begin
    logic exp_rdy, exp_vld, exp_acc;
    exp_rdy = reset && !flush && (q.size() < DEPTH);
    exp_vld = reset && !flush && (q.size() > 0) && (q[0].avail <= cyc);
    exp_acc = bus.pc_valid && exp_rdy;
    chk("pc_ready", bus.pc_ready, exp_rdy);
    chk("imem_req", bus.imem_req, exp_acc);
    if (exp_acc) chk("imem_addr", bus.imem_addr, bus.pc_in);
    chk("ir_valid", bus.ir_valid, exp_vld);
    if (exp_vld) begin
      chk("ir_pc", bus.ir_pc, q[0].pc);
      chk("ir_data", bus.ir_data, q[0].data);
    end
    if (!reset || flush) begin
      q.delete();
    end else begin
      if (exp_vld && bus.ir_ready) begin
        void'(q.pop_front());
        n_pop++;
      end
      if (exp_acc) q.push_back('{pc: bus.pc_in, data: 16'hA500 ^ {8'h00, bus.pc_in}, avail: cyc + 2});
    end
    cyc++;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nacc;
    int pops0;
    reset = 1'b0;
    flush = 1'b0;
    bus.pc_valid = 1'b1;
    bus.pc_in    = 8'h33;
    bus.ir_ready = 1'b1;

    // Reset held with pc_valid high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_imem_req", bus.imem_req, 1'b0);
      chk("rst_ir_valid", bus.ir_valid, 1'b0);
      if (i < 2) next_cycle();
    end
    next_cycle();
    reset = 1'b1;
    bus.pc_valid = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", bus.pc_ready, 1'b1);

    // Streaming 0x00..0x07 with decode always ready
    for (int j = 0; j < 10; j++) begin
      next_cycle();
      bus.pc_valid = (j < 8);
      bus.pc_in    = AW'(j);
      bus.ir_ready = 1'b1;
      @(negedge clk);
      if (j < 8) chk("stream_ready", bus.pc_ready, 1'b1);
      if (j >= 2) begin
        chk("stream_valid", bus.ir_valid, 1'b1);
        chk("stream_pc", bus.ir_pc, 32'(j - 2));
        chk("stream_data", bus.ir_data, 32'(16'hA500 + j - 2));
      end else begin
        chk("stream_lat", bus.ir_valid, 1'b0);
      end
    end

    // Backpressure: decode stalled while PCs keep coming
    nacc = 0;
    for (int j = 0; j < 8; j++) begin
      next_cycle();
      bus.pc_valid = 1'b1;
      bus.pc_in    = AW'(8'h20 + nacc);
      bus.ir_ready = 1'b0;
      @(negedge clk);
      if (bus.pc_valid && bus.pc_ready) nacc++;
      if (j >= 2) chk("bp_head", bus.ir_pc, 32'h20);
    end
    chk("bp_accepted", nacc, 4);
    chk("bp_full_ready", bus.pc_ready, 1'b0);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      bus.pc_valid = 1'b0;
      bus.ir_ready = 1'b1;
      @(negedge clk);
      if (k < 4) chk("bp_drain_pc", bus.ir_pc, 32'(8'h20 + k));
      else       chk("bp_drained", bus.ir_valid, 1'b0);
    end

    // Flush with a fetch in flight
    next_cycle();
    bus.pc_valid = 1'b1;
    bus.pc_in    = 8'h10;
    next_cycle();
    bus.pc_in = 8'h11;
    flush = 1'b1;
    @(negedge clk);
    chk("fl_ready", bus.pc_ready, 1'b0);
    next_cycle();
    flush = 1'b0;
    bus.pc_in = 8'h40;
    @(negedge clk);
    chk("fl_resume", bus.pc_ready, 1'b1);
    chk("fl_no_stale", bus.ir_valid, 1'b0);
    next_cycle();
    bus.pc_valid = 1'b0;
    @(negedge clk);
    chk("fl_lat", bus.ir_valid, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("fl_first_vld", bus.ir_valid, 1'b1);
    chk("fl_first_pc", bus.ir_pc, 32'h40);
    chk("fl_first_data", bus.ir_data, 32'hA540);

    // Simultaneous push/pop at 3 entries, then flush with ir_ready high
    for (int j = 0; j < 4; j++) begin
      next_cycle();
      bus.pc_valid = (j < 3);
      bus.pc_in    = AW'(8'h50 + j);
      bus.ir_ready = 1'b0;
    end
    next_cycle();
    bus.pc_valid = 1'b1;
    bus.pc_in    = 8'h53;
    @(negedge clk);
    chk("sim_occ3", dut.occ, 3);
    next_cycle();
    bus.pc_valid = 1'b0;
    bus.ir_ready = 1'b1;
    @(negedge clk);
    chk("sim_pop_pc", bus.ir_pc, 32'h50);
    next_cycle();
    @(negedge clk);
    chk("sim_occ_hold", dut.occ, 3);
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    chk("sim_occ2", dut.occ, 2);
    chk("sim_fl_nopop", bus.ir_valid, 1'b0);
    next_cycle();
    bus.pc_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("hold_fl_ready", bus.pc_ready, 1'b0);
      chk("hold_fl_occ", dut.occ, 0);
      next_cycle();
    end
    flush = 1'b0;
    bus.pc_valid = 1'b0;

    // Reset mid-operation discards everything
    for (int j = 0; j < 3; j++) begin
      next_cycle();
      bus.pc_valid = (j < 2);
      bus.pc_in    = AW'(8'h70 + j);
      bus.ir_ready = 1'b0;
    end
    next_cycle();
    reset = 1'b0;
    bus.pc_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", bus.ir_valid, 1'b0);
    next_cycle();
    reset = 1'b1;
    bus.pc_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_empty", bus.ir_valid, 1'b0);

    // Random traffic across pointer wrap
    nacc = 0;
    pops0 = n_pop;
    for (int j = 0; j < 300 && nacc < 3*DEPTH+1; j++) begin
      next_cycle();
      bus.pc_valid = ($urandom_range(3) != 0);
      bus.pc_in    = AW'($urandom);
      bus.ir_ready = $urandom_range(1);
      @(negedge clk);
      if (bus.pc_valid && bus.pc_ready) nacc++;
    end
    chk("wrap_accepted", nacc, 3*DEPTH+1);
    for (int j = 0; j < 8; j++) begin
      next_cycle();
      bus.pc_valid = 1'b0;
      bus.ir_ready = 1'b1;
    end
    @(negedge clk);
    chk("wrap_delivered", n_pop - pops0, 3*DEPTH+1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
